// File: rtl/grv_difftest_pkg.sv
// Shared types for the Difftest commit sequencer: queued commit record,
// sequencer state encoding and the per-cycle issue width.
package grv_difftest_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } commit_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int unsigned DT_SLOTS = 2;

    // Number of entries that can leave the FIFO in one issue cycle.
    function automatic logic [1:0] slots_avail(input int unsigned cnt);
        if (cnt >= DT_SLOTS) begin
            return 2'(DT_SLOTS);
        end
        return 2'(cnt);
    endfunction

endpackage

// File: rtl/difftest_commit_sequencer_if.sv
// ROB-commit and Difftest-issue signal bundle. Handshakes: a ROB lane is taken
// when rob_valid[i] && rob_ready; an issue happens whenever dt_ready=1 and data is queued.
interface difftest_commit_sequencer_if;

    logic [1:0]  rob_valid;
    logic [31:0] rob_pc0;
    logic [31:0] rob_pc1;
    logic [31:0] rob_data0;
    logic [31:0] rob_data1;
    logic        rob_ready;
    logic        halt_req;
    logic        dt_ready;
    logic [3:0]  commit_valid;
    logic [7:0]  commit_num;
    logic [31:0] commit_pc1;
    logic [31:0] commit_pc2;
    logic [31:0] commit_data1;
    logic [31:0] commit_data2;

    modport master (
        output rob_valid, rob_pc0, rob_pc1, rob_data0, rob_data1, halt_req, dt_ready,
        input  rob_ready, commit_valid, commit_num, commit_pc1, commit_pc2,
               commit_data1, commit_data2
    );

    modport slave (
        input  rob_valid, rob_pc0, rob_pc1, rob_data0, rob_data1, halt_req, dt_ready,
        output rob_ready, commit_valid, commit_num, commit_pc1, commit_pc2,
               commit_data1, commit_data2
    );

endinterface

// File: rtl/commit_fifo_2w2r.sv
// Circular buffer of commit records accepting 0-2 writes and 0-2 reads per cycle.
// Reads always expose the two oldest entries; the caller decides how many to pop.
module commit_fifo_2w2r
    import grv_difftest_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             wr_num,
    input  commit_entry_t          wr_entry0,
    input  commit_entry_t          wr_entry1,
    input  logic [1:0]             rd_num,
    output commit_entry_t          rd_entry0,
    output commit_entry_t          rd_entry1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;

    commit_entry_t mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx0;
    logic [AW-1:0] wr_idx1;
    logic [AW-1:0] rd_idx0;
    logic [AW-1:0] rd_idx1;

    assign wr_idx0 = wr_ptr[AW-1:0];
    assign wr_idx1 = wr_idx0 + AW'(1);
    assign rd_idx0 = rd_ptr[AW-1:0];
    assign rd_idx1 = rd_idx0 + AW'(1);

    assign rd_entry0 = mem[rd_idx0];
    assign rd_entry1 = mem[rd_idx1];

    // Pointers carry one extra bit and wrap naturally; count is tracked explicitly.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_num);
            rd_ptr <= rd_ptr + PW'(rd_num);
            count  <= count + PW'(wr_num) - PW'(rd_num);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_num != 2'd0) begin
            mem[wr_idx0] <= wr_entry0;
        end
        if (wr_num == 2'd2) begin
            mem[wr_idx1] <= wr_entry1;
        end
    end

endmodule

// File: rtl/difftest_commit_sequencer.sv
// Compacts 2-wide ROB commits into an in-order FIFO and issues up to two per cycle
// to the Difftest sink; drains on halt and raises a commit-stall watchdog.
module difftest_commit_sequencer
    import grv_difftest_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    difftest_commit_sequencer_if.slave   bus,
    output logic                         done,
    output logic                         hang,
    output logic [$clog2(DEPTH):0]       occupancy,
    output seq_state_t                   dbg_state
);

    localparam int PW = $clog2(DEPTH) + 1;

    seq_state_t    state;
    seq_state_t    state_next;
    logic [PW-1:0] count;
    logic [1:0]    wr_num;
    logic [1:0]    rd_num;
    logic          accepted;
    logic [15:0]   wd_cnt;

    commit_entry_t lane0;
    commit_entry_t lane1;
    commit_entry_t wr_entry0;
    commit_entry_t wr_entry1;
    commit_entry_t rd_entry0;
    commit_entry_t rd_entry1;

    // Ready depends only on registered state so the ROB sees no combinational path.
    assign bus.rob_ready = (count <= PW'(DEPTH - 2)) && (state == RUN);

    always_comb begin
        lane0.pc   = bus.rob_pc0;
        lane0.data = bus.rob_data0;
        lane1.pc   = bus.rob_pc1;
        lane1.data = bus.rob_data1;
        wr_entry0  = lane0;
        wr_entry1  = lane1;
        wr_num     = 2'd0;
        if (bus.rob_ready) begin
            case (bus.rob_valid)
                2'b01: wr_num = 2'd1;
                2'b10: begin
                    wr_num    = 2'd1;
                    wr_entry0 = lane1;
                end
                2'b11: wr_num = 2'd2;
                default: wr_num = 2'd0;
            endcase
        end
    end

    assign accepted = (wr_num != 2'd0);

    // Pops see only pre-push contents, so a commit never bypasses to the sink.
    assign rd_num = (bus.dt_ready && state != DONE) ? slots_avail(32'(count)) : 2'd0;

    commit_fifo_2w2r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_num    (wr_num),
        .wr_entry0 (wr_entry0),
        .wr_entry1 (wr_entry1),
        .rd_num    (rd_num),
        .rd_entry0 (rd_entry0),
        .rd_entry1 (rd_entry1),
        .count     (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.commit_valid <= '0;
            bus.commit_num   <= '0;
            bus.commit_pc1   <= '0;
            bus.commit_pc2   <= '0;
            bus.commit_data1 <= '0;
            bus.commit_data2 <= '0;
        end else begin
            bus.commit_valid <= {2'b00, (rd_num == 2'd2), (rd_num != 2'd0)};
            bus.commit_num   <= {6'd0, rd_num};
            bus.commit_pc1   <= (rd_num != 2'd0) ? rd_entry0.pc   : '0;
            bus.commit_data1 <= (rd_num != 2'd0) ? rd_entry0.data : '0;
            bus.commit_pc2   <= (rd_num == 2'd2) ? rd_entry1.pc   : '0;
            bus.commit_data2 <= (rd_num == 2'd2) ? rd_entry1.data : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.halt_req) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    // Watchdog only runs while the ROB is allowed to commit; the counter saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
            hang   <= 1'b0;
        end else if (accepted || state != RUN) begin
            wd_cnt <= '0;
        end else begin
            if (wd_cnt == 16'(TIMEOUT - 1)) begin
                hang <= 1'b1;
            end
            if (wd_cnt != 16'hFFFF) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end

    assign done      = (state == DONE);
    assign occupancy = count;
    assign dbg_state = state;

endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// Directed bench for difftest_commit_sequencer: expected commits are queued at
// stimulus time and a negedge monitor pops and compares every issued slot.
module tb_difftest_commit_sequencer;
    import grv_difftest_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       done;
    logic       hang;
    logic [3:0] occupancy;
    seq_state_t dbg_state;

    difftest_commit_sequencer_if bus();

    difftest_commit_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .hang      (hang),
        .occupancy (occupancy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard
    logic [63:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    always @(negedge clock) begin
        if (!reset && (bus.commit_valid != 4'd0 || bus.commit_num != 8'd0)) begin
            check("valid_shape", 64'(bus.commit_valid),
                  bus.commit_valid[1] ? 64'h3 : 64'h1);
            check("num_vs_valid", 64'(bus.commit_num),
                  64'(bus.commit_valid[0]) + 64'(bus.commit_valid[1]));
            if (bus.commit_valid[0]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL slot1_unexpected: actual=0x%0h required=none",
                             {bus.commit_pc1, bus.commit_data1});
                end else begin
                    check("slot1", {bus.commit_pc1, bus.commit_data1}, exp_q.pop_front());
                end
            end
            if (bus.commit_valid[1]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL slot2_unexpected: actual=0x%0h required=none",
                             {bus.commit_pc2, bus.commit_data2});
                end else begin
                    check("slot2", {bus.commit_pc2, bus.commit_data2}, exp_q.pop_front());
                end
            end else if (bus.commit_valid[0]) begin
                check("slot2_zero", {bus.commit_pc2, bus.commit_data2}, 64'd0);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rob_valid = 2'b00;
        bus.rob_pc0   = '0;
        bus.rob_pc1   = '0;
        bus.rob_data0 = '0;
        bus.rob_data1 = '0;
        bus.halt_req  = 1'b0;
    endtask

    task automatic push_cycle(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] d0,
                              input logic [31:0] pc1, input logic [31:0] d1,
                              input logic exp_ready, input logic halt);
        bus.rob_valid = v;
        bus.rob_pc0   = pc0;
        bus.rob_data0 = d0;
        bus.rob_pc1   = pc1;
        bus.rob_data1 = d1;
        bus.halt_req  = halt;
        check("rob_ready_at_push", 64'(bus.rob_ready), 64'(exp_ready));
        if (exp_ready) begin
            if (v[0]) exp_q.push_back({pc0, d0});
            if (v[1]) exp_q.push_back({pc1, d1});
        end
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        exp_q.delete();
        step();
        check("rst_commit_num",   64'(bus.commit_num), 64'd0);
        check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        check("rst_occupancy",    64'(occupancy), 64'd0);
        check("rst_rob_ready",    64'(bus.rob_ready), 64'd1);
        check("rst_done",         64'(done), 64'd0);
        check("rst_hang",         64'(hang), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.dt_ready = 1'b0;
        do_reset();

        // Watchdog with no commits: hang after 16 cycles.
        repeat (15) step();
        check("hang_at_15", 64'(hang), 64'd0);
        step();
        check("hang_at_16", 64'(hang), 64'd1);

        // Reset mid-stream with 6 queued entries (hang does not block enqueue).
        bus.dt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cycle(2'b11, 32'h8000_0200 + 32'(i * 8), 32'h200 + 32'(i),
                       32'h8000_0204 + 32'(i * 8), 32'h300 + 32'(i), 1'b1, 1'b0);
        end
        check("occ_before_reset", 64'(occupancy), 64'd6);
        check("hang_sticky", 64'(hang), 64'd1);
        bus.dt_ready = 1'b1;
        do_reset();
        step();
        check("no_issue_after_reset", 64'(bus.commit_num), 64'd0);

        // Watchdog restart: a commit at cycle 10 postpones hang to cycle 26.
        do_reset();
        bus.dt_ready = 1'b1;
        repeat (9) step();
        push_cycle(2'b01, 32'h8000_1000, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (6) step();
        check("hang_restart_16", 64'(hang), 64'd0);
        repeat (9) step();
        check("hang_restart_25", 64'(hang), 64'd0);
        step();
        check("hang_restart_26", 64'(hang), 64'd1);

        // Single lane, one-cycle latency.
        do_reset();
        bus.dt_ready = 1'b1;
        push_cycle(2'b01, 32'h8000_0000, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t1_no_bypass", 64'(bus.commit_num), 64'd0);
        step();
        check("t1_num",   64'(bus.commit_num), 64'd1);
        check("t1_valid", 64'(bus.commit_valid), 64'h1);
        check("t1_pc1",   64'(bus.commit_pc1), 64'h8000_0000);
        check("t1_data1", 64'(bus.commit_data1), 64'd5);

        // Lane compaction: lane1-only then both lanes.
        push_cycle(2'b10, 32'h0, 32'h0, 32'h8000_0004, 32'h44, 1'b1, 1'b0);
        push_cycle(2'b11, 32'h8000_0008, 32'h88, 32'h8000_000C, 32'hCC, 1'b1, 1'b0);
        check("t2_num_a", 64'(bus.commit_num), 64'd1);
        check("t2_pc1_a", 64'(bus.commit_pc1), 64'h8000_0004);
        step();
        check("t2_num_b", 64'(bus.commit_num), 64'd2);
        check("t2_pc1_b", 64'(bus.commit_pc1), 64'h8000_0008);
        check("t2_pc2_b", 64'(bus.commit_pc2), 64'h8000_000C);
        step();
        check("t2_idle_num", 64'(bus.commit_num), 64'd0);

        // Backpressure: fill to DEPTH, ignored push while full, then drain 2/cycle.
        bus.dt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cycle(2'b11, 32'h8000_0100 + 32'(i * 16), 32'h1000 + 32'(i),
                       32'h8000_0108 + 32'(i * 16), 32'h2000 + 32'(i), 1'b1, 1'b0);
        end
        check("t3_occ_full", 64'(occupancy), 64'd8);
        push_cycle(2'b11, 32'hDEAD_0000, 32'h1, 32'hDEAD_0004, 32'h2, 1'b0, 1'b0);
        check("t3_occ_ignored", 64'(occupancy), 64'd8);
        bus.dt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_drain_num", 64'(bus.commit_num), 64'd2);
            check("t3_drain_occ", 64'(occupancy), 64'(6 - 2 * i));
        end
        step();
        check("t3_after_num", 64'(bus.commit_num), 64'd0);

        // Odd fill: 7 entries already block a 2-wide commit.
        bus.dt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cycle(2'b11, 32'h8000_0400 + 32'(i * 8), 32'h40 + 32'(i),
                       32'h8000_0404 + 32'(i * 8), 32'h50 + 32'(i), 1'b1, 1'b0);
        end
        push_cycle(2'b01, 32'h8000_0480, 32'h60, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t3_occ_7", 64'(occupancy), 64'd7);
        check("t3_ready_at_7", 64'(bus.rob_ready), 64'd0);
        bus.dt_ready = 1'b1;
        step();
        check("t3_odd_num0", 64'(bus.commit_num), 64'd2);
        step();
        check("t3_odd_num1", 64'(bus.commit_num), 64'd2);
        step();
        check("t3_odd_num2", 64'(bus.commit_num), 64'd2);
        step();
        check("t3_odd_num3", 64'(bus.commit_num), 64'd1);
        check("t3_odd_occ", 64'(occupancy), 64'd0);

        // Halt drain: 5 queued plus 2 committed with the halt pulse.
        bus.dt_ready = 1'b0;
        push_cycle(2'b11, 32'h8000_0500, 32'h501, 32'h8000_0504, 32'h502, 1'b1, 1'b0);
        push_cycle(2'b11, 32'h8000_0508, 32'h503, 32'h8000_050C, 32'h504, 1'b1, 1'b0);
        push_cycle(2'b01, 32'h8000_0510, 32'h505, 32'h0, 32'h0, 1'b1, 1'b0);
        bus.dt_ready = 1'b1;
        push_cycle(2'b11, 32'h8000_0514, 32'h506, 32'h8000_0518, 32'h507, 1'b1, 1'b1);
        check("t4_num_h", 64'(bus.commit_num), 64'd2);
        check("t4_ready_drain", 64'(bus.rob_ready), 64'd0);
        check("t4_state_drain", 64'(dbg_state), 64'(DRAIN));
        bus.rob_valid = 2'b11;
        bus.rob_pc0   = 32'hBAD0_0000;
        bus.rob_pc1   = 32'hBAD0_0004;
        step();
        check("t4_num_h1", 64'(bus.commit_num), 64'd2);
        step();
        check("t4_num_h2", 64'(bus.commit_num), 64'd2);
        step();
        check("t4_num_h3", 64'(bus.commit_num), 64'd1);
        check("t4_occ_zero", 64'(occupancy), 64'd0);
        check("t4_done_early", 64'(done), 64'd0);
        step();
        check("t4_done", 64'(done), 64'd1);
        check("t4_num_done", 64'(bus.commit_num), 64'd0);
        idle_inputs();
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        repeat (20) step();
        check("t4_done_sticky", 64'(done), 64'd1);
        check("t4_hang_in_done", 64'(hang), 64'd0);
        check("t4_ready_done", 64'(bus.rob_ready), 64'd0);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
